// File: rtl/alu_serial_if.sv
// Handshake and data bundle between the control unit and the bit-serial ALU sequencer.
interface alu_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, alu_ctl, a, b,
    input  busy, done, result, zero, overflow, illegal
  );

  modport slave (
    input  start, alu_ctl, a, b,
    output busy, done, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice time-shared across WIDTH bits, LSB first,
// with an extra fix-up cycle for SLT so the compare is signed-correct.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_serial_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  function automatic logic ctl_is_legal(input logic [3:0] ctl);
    case (ctl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: ctl_is_legal = 1'b1;
      default: ctl_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic ctl_is_addsub(input logic [3:0] ctl);
    case (ctl)
      4'b0010, 4'b0110: ctl_is_addsub = 1'b1;
      default: ctl_is_addsub = 1'b0;
    endcase
  endfunction

  // The "less" select always writes 0 here; SLT patches bit 0 in FIX.
  function automatic logic slice_out(input logic ai, input logic bi, input logic sum,
                                     input logic [1:0] sel);
    case (sel)
      2'b00:   slice_out = ai & bi;
      2'b01:   slice_out = ai | bi;
      2'b10:   slice_out = sum;
      2'b11:   slice_out = 1'b0;
      default: slice_out = 1'b0;
    endcase
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       ctl_r;
  logic [WIDTH-1:0] shreg_r;
  logic             set_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             overflow_r;
  logic             illegal_r;

  logic             ai_s;
  logic             bi_s;
  logic             sum_s;
  logic             cout_s;
  logic             bit_s;
  logic             last_s;
  logic [WIDTH-1:0] run_word_s;
  logic [WIDTH-1:0] fix_word_s;
  logic [WIDTH-1:0] final_s;
  logic             ovf_out_s;

  // One slice evaluation for the current bit plus the candidate completed words.
  always_comb begin
    ai_s       = a_r[cnt_r] ^ ctl_r[3];
    bi_s       = b_r[cnt_r] ^ ctl_r[2];
    sum_s      = ai_s ^ bi_s ^ carry_r;
    cout_s     = (ai_s & bi_s) | (carry_r & (ai_s ^ bi_s));
    bit_s      = slice_out(ai_s, bi_s, sum_s, ctl_r[1:0]);
    last_s     = (cnt_r == CW'(WIDTH - 1));
    run_word_s = {bit_s, shreg_r[WIDTH-1:1]};
    fix_word_s = shreg_r | {{(WIDTH-1){1'b0}}, set_r ^ ovf_r};
    if (!ctl_is_legal(ctl_r)) begin
      final_s = {WIDTH{1'b0}};
    end else if (state_r == FIX) begin
      final_s = fix_word_s;
    end else begin
      final_s = run_word_s;
    end
    ovf_out_s = ctl_is_addsub(ctl_r) ? (cout_s ^ carry_r) : 1'b0;
  end

  // Sequencer FSM; visible outputs load together only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      carry_r    <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      ctl_r      <= 4'b0000;
      shreg_r    <= {WIDTH{1'b0}};
      set_r      <= 1'b0;
      ovf_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      zero_r     <= 1'b0;
      overflow_r <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r <= RUN;
            a_r     <= bus.a;
            b_r     <= bus.b;
            ctl_r   <= bus.alu_ctl;
            cnt_r   <= {CW{1'b0}};
            carry_r <= bus.alu_ctl[2];
            shreg_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          carry_r <= cout_s;
          shreg_r <= run_word_s;
          if (last_s) begin
            set_r <= sum_s;
            ovf_r <= cout_s ^ carry_r;
            if (ctl_r == 4'b0111) begin
              state_r <= FIX;
            end else begin
              state_r    <= DONE;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              result_r   <= final_s;
              zero_r     <= (final_s == {WIDTH{1'b0}});
              overflow_r <= ovf_out_s;
              illegal_r  <= ~ctl_is_legal(ctl_r);
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        FIX: begin
          shreg_r    <= fix_word_s;
          state_r    <= DONE;
          busy_r     <= 1'b0;
          done_r     <= 1'b1;
          result_r   <= final_s;
          zero_r     <= (final_s == {WIDTH{1'b0}});
          overflow_r <= 1'b0;
          illegal_r  <= 1'b0;
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.zero     = zero_r;
  assign bus.overflow = overflow_r;
  assign bus.illegal  = illegal_r;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: the driver queues expected results, a monitor
// pops and compares them whenever done is seen.
module tb_alu_serial_ctrl;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        il;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_serial_if #(.WIDTH(32)) bus ();

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard and checks done width.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) check("done_width", {31'd0, bus.done}, 32'd0);
        if (bus.done === 1'b1) begin
          if (sb.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("result",   bus.result, e.res);
            check("zero",     {31'd0, bus.zero}, {31'd0, e.z});
            check("overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
            check("illegal",  {31'd0, bus.illegal}, {31'd0, e.il});
            check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            check("latency",  cyc - e.acc, e.lat);
          end
        end
        prev_done = bus.done;
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    if (bus.done !== 1'b1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic run_op(input logic [3:0] ctl, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] er, input logic ez, input logic eov,
                        input logic eil, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.alu_ctl = ctl;
    bus.a       = aa;
    bus.b       = bb;
    @(posedge clk);
    #1;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    e.res = er; e.z = ez; e.ov = eov; e.il = eil; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
  endtask

  initial begin
    exp_t e;
    int   acc1;
    int   n;
    checks      = 0;
    errors      = 0;
    bus.start   = 1'b0;
    bus.alu_ctl = 4'b0000;
    bus.a       = 32'd0;
    bus.b       = 32'd0;
    rst         = 1'b1;
    #1;
    check("rst_busy",     {31'd0, bus.busy}, 32'd0);
    check("rst_done",     {31'd0, bus.done}, 32'd0);
    check("rst_result",   bus.result, 32'd0);
    check("rst_zero",     {31'd0, bus.zero}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_illegal",  {31'd0, bus.illegal}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32);
    run_op(4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32);
    run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 32);
    run_op(4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33);
    run_op(4'b0111, 32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 33);
    run_op(4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, 1'b0, 1'b0, 1'b0, 32);
    run_op(4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0, 32);
    run_op(4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 32);

    // Abort an ADD while bit 10 is being processed; nothing is queued for it.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.alu_ctl = 4'b0010;
    bus.a       = 32'h1234_5678;
    bus.b       = 32'h0000_0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy",   {31'd0, bus.busy}, 32'd0);
    check("abort_done",   {31'd0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'b0010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32);

    // Illegal code with start held high: one op per IDLE entry, result held during RUN.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.alu_ctl = 4'b0101;
    bus.a       = 32'hDEAD_BEEF;
    bus.b       = 32'h1234_5678;
    @(posedge clk);
    #1;
    acc1 = cyc;
    e.res = 32'd0; e.z = 1'b1; e.ov = 1'b0; e.il = 1'b1; e.acc = acc1; e.lat = 32;
    sb.push_back(e);
    e.acc = acc1 + 34;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 100) begin
      check("hold_result_stable1", bus.result, 32'h0000_0005);
      @(negedge clk);
      n = n + 1;
    end
    wait_done();
    @(negedge clk);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      check("hold_result_stable2", bus.result, 32'h0000_0000);
      @(negedge clk);
      n = n + 1;
    end
    wait_done();
    bus.start = 1'b0;

    repeat (40) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
